// File: rtl/accumulator_arbiter.sv
// accumulator_arbiter: shares one accumulator between N_REQ requester streams.
// Whole packets (up to the eot beat) are granted without interleaving. Each started
// packet pushes its owner index into a tag FIFO. Accumulator results are routed back
// to the owner at the FIFO head.
// Optional build macro: ACCUMULATOR_ARBITER_FIXED_PRIO_EN selects fixed priority
// (lowest index wins). When it is left undefined, round-robin arbitration is used.

// Protocol checker: a result must never arrive while no packet is outstanding.
module accumulator_arbiter_chk (
   input logic clk,
   input logic rst,
   input logic res_valid_i,
   input logic fifo_empty
);
   a_no_result_when_empty: assert property (
      @(posedge clk) disable iff (rst) !(res_valid_i && fifo_empty));
endmodule

module accumulator_arbiter #(
   parameter int N_REQ     = 2,
   parameter int W_DATA    = 16,
   parameter int TAG_DEPTH = 4
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [N_REQ-1:0]                req_valid,
   output logic [N_REQ-1:0]                req_ready,
   input  logic [N_REQ*(2*W_DATA+1)-1:0]   req_data,
   output logic                            acc_valid,
   input  logic                            acc_ready,
   output logic [2*W_DATA:0]               acc_data,
   input  logic                            res_valid_i,
   output logic                            res_ready_o,
   input  logic [W_DATA-1:0]               res_data_i,
   output logic [N_REQ-1:0]                res_valid,
   input  logic [N_REQ-1:0]                res_ready,
   output logic [W_DATA-1:0]               res_data
);
   localparam int BEAT_W = 2*W_DATA + 1;
   localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int AW     = $clog2(TAG_DEPTH);

   typedef enum logic {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} state_t;

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  owner_q, owner_d;
   logic [IDX_W-1:0]  rr_ptr_q;
   logic [IDX_W-1:0]  tag_mem_q [TAG_DEPTH];
   logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
   logic [AW:0]       count_q;

   logic [IDX_W:0]    pick_s;
   logic [IDX_W-1:0]  grant_s, sel_s, head_s;
   logic              grant_found_s, sel_en_s;
   logic              beat_hs_s, beat_eot_s, push_s, pop_s;
   logic              fifo_full_s, fifo_empty_s;

   // First valid requester at or after ptr (cyclic); returns {found, index}.
   function automatic logic [IDX_W:0] rr_pick(input logic [N_REQ-1:0] valid,
                                               input logic [IDX_W-1:0] ptr);
      logic [IDX_W:0] res;
      int             cand;
      res = '0;
      for (int i = N_REQ-1; i >= 0; i--) begin
         cand = int'(ptr) + i;
         if (cand >= N_REQ) begin
            cand = cand - N_REQ;
         end else begin
            cand = cand;
         end
         if (valid[IDX_W'(cand)]) begin
            res = {1'b1, IDX_W'(cand)};
         end else begin
            res = res;
         end
      end
      return res;
   endfunction

   assign fifo_full_s  = (count_q == (AW+1)'(TAG_DEPTH));
   assign fifo_empty_s = (count_q == (AW+1)'(0));
   assign head_s       = tag_mem_q[rd_ptr_q];

   assign pick_s        = rr_pick(req_valid, rr_ptr_q);
   assign grant_found_s = pick_s[IDX_W];
   assign grant_s       = pick_s[IDX_W-1:0];

`ifdef ACCUMULATOR_ARBITER_FIXED_PRIO_EN
   // Fixed priority: scanning always starts at requester 0.
   assign rr_ptr_q = '0;
`else
   logic [IDX_W-1:0] rr_ptr_d;

   // Next round-robin pointer: one past the owner of the packet that just ended.
   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (beat_hs_s && beat_eot_s) begin
         if (sel_s == IDX_W'(N_REQ-1)) begin
            rr_ptr_d = '0;
         end else begin
            rr_ptr_d = sel_s + IDX_W'(1);
         end
      end else begin
         rr_ptr_d = rr_ptr_q;
      end
   end

   // Round-robin pointer register.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_q <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
      end
   end
`endif

   // Packet FSM next state plus the combinational forward of the selected requester.
   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      sel_s    = owner_q;
      sel_en_s = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!fifo_full_s && grant_found_s) begin
               sel_s    = grant_s;
               sel_en_s = 1'b1;
            end else begin
               sel_s    = owner_q;
               sel_en_s = 1'b0;
            end
         end
         ST_LOCKED: begin
            sel_s    = owner_q;
            sel_en_s = 1'b1;
         end
         default: begin
            sel_s    = owner_q;
            sel_en_s = 1'b0;
         end
      endcase
      acc_valid  = sel_en_s & req_valid[sel_s];
      acc_data   = req_data[int'(sel_s)*BEAT_W +: BEAT_W];
      req_ready  = sel_en_s ? (N_REQ'(acc_ready) << sel_s) : '0;
      beat_hs_s  = acc_valid & acc_ready;
      beat_eot_s = acc_data[BEAT_W-1];
      push_s     = beat_hs_s & (state_q == ST_IDLE);
      if (beat_hs_s) begin
         if (beat_eot_s) begin
            state_d = ST_IDLE;
         end else begin
            state_d = ST_LOCKED;
            owner_d = sel_s;
         end
      end else begin
         state_d = state_q;
      end
   end

   // FSM state and packet owner registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         owner_q <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
      end
   end

   // Result routing: only the head owner sees the result, and only while a tag is queued.
   always_comb begin
      res_data    = res_data_i;
      res_valid   = '0;
      res_ready_o = 1'b0;
      if (!fifo_empty_s) begin
         res_valid   = N_REQ'(res_valid_i) << head_s;
         res_ready_o = res_ready[head_s];
      end else begin
         res_valid   = '0;
         res_ready_o = 1'b0;
      end
      pop_s = res_valid_i & res_ready_o;
   end

   // Tag storage; entries are only read while the count says they are valid.
   always_ff @(posedge clk) begin
      if (push_s) begin
         tag_mem_q[wr_ptr_q] <= sel_s;
      end
   end

   // Tag FIFO pointers and occupancy; a push and pop in the same cycle leave count alone.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_s) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (pop_s) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         case ({push_s, pop_s})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   accumulator_arbiter_chk u_chk (
      .clk         (clk),
      .rst         (rst),
      .res_valid_i (res_valid_i),
      .fifo_empty  (fifo_empty_s)
   );
endmodule

// File: tb/tb_accumulator_arbiter.sv
// Directed bench for accumulator_arbiter (N_REQ=4, TAG_DEPTH=2) with an accumulator
// stub (result = first-beat offset + sum of data, one cycle after eot) and a result
// scoreboard.
module tb_accumulator_arbiter;
   localparam int N  = 4;
   localparam int W  = 16;
   localparam int TD = 2;
   localparam int BW = 2*W + 1;
`ifdef ACCUMULATOR_ARBITER_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req_valid, req_ready;
   logic [N*BW-1:0] req_data;
   logic            acc_valid, acc_ready;
   logic [BW-1:0]   acc_data;
   logic            res_valid_i, res_ready_o;
   logic [W-1:0]    res_data_i;
   logic [N-1:0]    res_valid, res_ready;
   logic [W-1:0]    res_data;

   typedef struct {
      int           owner;
      logic [W-1:0] val;
   } exp_t;

   exp_t          exp_q [$];
   logic [BW-1:0] src_q [N][$];
   logic [W-1:0]  acc_res_q [$];
   logic [W-1:0]  acc_sum;
   logic          acc_first;
   int            n_pass = 0;
   int            n_fail = 0;

   always #5 clk = ~clk;

   accumulator_arbiter #(.N_REQ(N), .W_DATA(W), .TAG_DEPTH(TD)) u_dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
      .acc_valid(acc_valid), .acc_ready(acc_ready), .acc_data(acc_data),
      .res_valid_i(res_valid_i), .res_ready_o(res_ready_o), .res_data_i(res_data_i),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
   );

   function automatic logic [BW-1:0] mk(input logic eot, input logic [W-1:0] off,
                                        input logic [W-1:0] d);
      return {eot, off, d};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive_srcs();
      for (int i = 0; i < N; i++) begin
         if (src_q[i].size() > 0) begin
            req_valid[i]         = 1'b1;
            req_data[i*BW +: BW] = src_q[i][0];
         end else begin
            req_valid[i]         = 1'b0;
            req_data[i*BW +: BW] = '0;
         end
      end
      res_valid_i = (acc_res_q.size() > 0);
      res_data_i  = (acc_res_q.size() > 0) ? acc_res_q[0] : '0;
   endtask

   task automatic expect_fwd(input string tag, input logic [N-1:0] rdy, input logic vld,
                             input logic [BW-1:0] beat);
      #1;
      check({tag, "_ready"}, req_ready, rdy);
      check({tag, "_accv"}, acc_valid, vld);
      if (vld) check({tag, "_data"}, acc_data, beat);
   endtask

   // One clock: sample handshakes at negedge, score results, advance sources and stub.
   task automatic cycle();
      logic [N-1:0]  hs_req;
      logic          hs_acc, hs_res;
      logic [BW-1:0] beat;
      logic [W-1:0]  sum;
      exp_t          e;
      @(negedge clk);
      hs_req = req_valid & req_ready;
      hs_acc = acc_valid & acc_ready;
      hs_res = res_valid_i & res_ready_o;
      beat   = acc_data;
      if (hs_res) begin
         check("res_expected", (exp_q.size() != 0), 1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("res_owner", res_valid, N'(1) << e.owner);
            check("res_data", res_data, e.val);
         end
      end
      @(posedge clk);
      #1;
      if (rst) begin
         for (int i = 0; i < N; i++) src_q[i].delete();
         acc_res_q.delete();
         exp_q.delete();
         acc_first = 1'b1;
         acc_sum   = '0;
      end else begin
         for (int i = 0; i < N; i++) if (hs_req[i]) void'(src_q[i].pop_front());
         if (hs_res) void'(acc_res_q.pop_front());
         if (hs_acc) begin
            sum = acc_first ? (beat[2*W-1:W] + beat[W-1:0]) : (acc_sum + beat[W-1:0]);
            if (beat[BW-1]) begin
               acc_res_q.push_back(sum);
               acc_first = 1'b1;
            end else begin
               acc_sum   = sum;
               acc_first = 1'b0;
            end
         end
      end
      drive_srcs();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   initial begin
      logic [BW-1:0] t2_beat [6];
      logic [N-1:0]  t2_rdy  [6];
      logic [BW-1:0] b;
      rst = 1'b1; acc_ready = 1'b0; res_ready = '0;
      req_valid = '0; req_data = '0; res_valid_i = 1'b0; res_data_i = '0;
      acc_first = 1'b1; acc_sum = '0;
      run(2);
      rst = 1'b0;
      #1;
      check("rst_req_ready", req_ready, 0);
      check("rst_acc_valid", acc_valid, 0);
      check("rst_res_valid", res_valid, 0);
      check("rst_res_ready_o", res_ready_o, 0);

      // Single-beat packets from all four requesters, results one cycle behind.
      acc_ready = 1'b1; res_ready = '1;
      for (int i = 0; i < N; i++) begin
         src_q[i].push_back(mk(1'b1, 16'(16*i), 16'(i+1)));
         exp_q.push_back('{i, 16'(17*i+1)});
      end
      drive_srcs();
      for (int i = 0; i < N; i++) begin
         b = mk(1'b1, 16'(16*i), 16'(i+1));
         expect_fwd("single", N'(1) << i, 1'b1, b);
         cycle();
      end
      run(2);
      check("single_drained", exp_q.size(), 0);

      // Contention: req0 holds two 2-beat packets, req1 one.
      src_q[0].push_back(mk(1'b0, 16'd3, 16'd1)); src_q[0].push_back(mk(1'b1, 16'd3, 16'd2));
      src_q[0].push_back(mk(1'b0, 16'd0, 16'd4)); src_q[0].push_back(mk(1'b1, 16'd0, 16'd5));
      src_q[1].push_back(mk(1'b0, 16'd7, 16'd10)); src_q[1].push_back(mk(1'b1, 16'd7, 16'd20));
      t2_beat[0] = mk(1'b0, 16'd3, 16'd1); t2_rdy[0] = 4'b0001;
      t2_beat[1] = mk(1'b1, 16'd3, 16'd2); t2_rdy[1] = 4'b0001;
      if (FIXED) begin
         t2_beat[2] = mk(1'b0, 16'd0, 16'd4);  t2_rdy[2] = 4'b0001;
         t2_beat[3] = mk(1'b1, 16'd0, 16'd5);  t2_rdy[3] = 4'b0001;
         t2_beat[4] = mk(1'b0, 16'd7, 16'd10); t2_rdy[4] = 4'b0010;
         t2_beat[5] = mk(1'b1, 16'd7, 16'd20); t2_rdy[5] = 4'b0010;
         exp_q.push_back('{0, 16'd6}); exp_q.push_back('{0, 16'd9}); exp_q.push_back('{1, 16'd37});
      end else begin
         t2_beat[2] = mk(1'b0, 16'd7, 16'd10); t2_rdy[2] = 4'b0010;
         t2_beat[3] = mk(1'b1, 16'd7, 16'd20); t2_rdy[3] = 4'b0010;
         t2_beat[4] = mk(1'b0, 16'd0, 16'd4);  t2_rdy[4] = 4'b0001;
         t2_beat[5] = mk(1'b1, 16'd0, 16'd5);  t2_rdy[5] = 4'b0001;
         exp_q.push_back('{0, 16'd6}); exp_q.push_back('{1, 16'd37}); exp_q.push_back('{0, 16'd9});
      end
      drive_srcs();
      for (int k = 0; k < 6; k++) begin
         expect_fwd("contend", t2_rdy[k], 1'b1, t2_beat[k]);
         cycle();
      end
      run(2);
      check("contend_drained", exp_q.size(), 0);

      // Single requester, three-beat packet: 5 + 1 + 2 + 3.
      src_q[0].push_back(mk(1'b0, 16'd5, 16'd1));
      src_q[0].push_back(mk(1'b0, 16'd5, 16'd2));
      src_q[0].push_back(mk(1'b1, 16'd5, 16'd3));
      exp_q.push_back('{0, 16'd11});
      drive_srcs();
      for (int k = 0; k < 3; k++) begin
         b = mk((k == 2), 16'd5, 16'(k+1));
         expect_fwd("pkt3", 4'b0001, 1'b1, b);
         cycle();
      end
      #1;
      check("pkt3_res_valid", res_valid, 4'b0001);
      check("pkt3_res_data", res_data, 16'd11);
      cycle();
      #1;
      check("pkt3_empty_valid", res_valid, 0);
      check("pkt3_empty_ready", res_ready_o, 0);
      check("pkt3_drained", exp_q.size(), 0);

      // Tag FIFO full: results held back, third packet waits until the first pops.
      res_ready = '0;
      src_q[1].push_back(mk(1'b1, 16'd100, 16'd1)); exp_q.push_back('{1, 16'd101});
      src_q[2].push_back(mk(1'b1, 16'd200, 16'd2)); exp_q.push_back('{2, 16'd202});
      src_q[3].push_back(mk(1'b1, 16'd300, 16'd3)); exp_q.push_back('{3, 16'd303});
      drive_srcs();
      expect_fwd("full_p1", 4'b0010, 1'b1, mk(1'b1, 16'd100, 16'd1));
      cycle();
      expect_fwd("full_p2", 4'b0100, 1'b1, mk(1'b1, 16'd200, 16'd2));
      check("full_res_valid", res_valid, 4'b0010);
      check("full_res_ready_o", res_ready_o, 0);
      cycle();
      for (int k = 0; k < 2; k++) begin
         expect_fwd("full_block", 4'b0000, 1'b0, '0);
         check("full_hold_valid", res_valid, 4'b0010);
         cycle();
      end
      res_ready = '1;
      expect_fwd("full_popcyc", 4'b0000, 1'b0, '0);
      cycle();
      expect_fwd("full_p3", 4'b1000, 1'b1, mk(1'b1, 16'd300, 16'd3));
      check("full_pushpop_owner", res_valid, 4'b0100);
      cycle();
      run(2);
      check("full_drained", exp_q.size(), 0);

      // Reset during beat 2 of 3, then a fresh packet from req1.
      src_q[0].push_back(mk(1'b0, 16'd9, 16'd1));
      src_q[0].push_back(mk(1'b0, 16'd9, 16'd2));
      src_q[0].push_back(mk(1'b1, 16'd9, 16'd3));
      drive_srcs();
      expect_fwd("rstpkt_b1", 4'b0001, 1'b1, mk(1'b0, 16'd9, 16'd1));
      cycle();
      rst = 1'b1;
      expect_fwd("rstpkt_b2", 4'b0001, 1'b1, mk(1'b0, 16'd9, 16'd2));
      cycle();
      rst = 1'b0;
      #1;
      check("midrst_req_ready", req_ready, 0);
      check("midrst_acc_valid", acc_valid, 0);
      check("midrst_res_valid", res_valid, 0);
      check("midrst_res_ready_o", res_ready_o, 0);
      cycle();
      src_q[1].push_back(mk(1'b0, 16'd2, 16'd8));
      src_q[1].push_back(mk(1'b1, 16'd2, 16'd9));
      exp_q.push_back('{1, 16'd19});
      drive_srcs();
      expect_fwd("after_rst_b1", 4'b0010, 1'b1, mk(1'b0, 16'd2, 16'd8));
      cycle();
      expect_fwd("after_rst_b2", 4'b0010, 1'b1, mk(1'b1, 16'd2, 16'd9));
      cycle();
      run(2);
      check("after_rst_drained", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
      $finish;
   end
endmodule
